// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared pipeline definitions: forward-mux codes, hazard FSM states and stage records.
package hazard_fwd_ctrl_pkg;

  localparam int unsigned RegW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [RegW-1:0] REG_ZERO = '0;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StStall = 1'b1
  } state_e;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memread;
    logic [RegW-1:0] rd;
  } stage_rec_t;

  typedef struct packed {
    stage_rec_t      base;
    logic [RegW-1:0] rs;
    logic [RegW-1:0] rt;
    logic            usesrt;
  } ex_rec_t;

  // True when a stage will write a non-zero register that matches src.
  function automatic logic writes_src(stage_rec_t rec, logic [RegW-1:0] src);
    return rec.valid && rec.regwrite && (rec.rd != REG_ZERO) && (rec.rd == src);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Single-operand forward select; the younger MEM result wins over WB.
module fwd_sel
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic [RegW-1:0] src_i,
  input  stage_rec_t      mem_i,
  input  stage_rec_t      wb_i,
  output logic [1:0]      fwd_o
);

  // Load flags are not needed to pick a source.
  logic unused_memread;
  assign unused_memread = mem_i.memread ^ wb_i.memread;

  always_comb begin
    fwd_o = FWD_REG;
    if (writes_src(mem_i, src_i)) begin
      fwd_o = FWD_MEM;
    end else if (writes_src(wb_i, src_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// EX/MEM/WB shadow pipeline driving operand forwarding, load-use stall and stall statistics.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            ID_valid_i,
  input  logic [RegW-1:0] ID_RS_i,
  input  logic [RegW-1:0] ID_RT_i,
  input  logic            ID_UsesRT_i,
  input  logic [RegW-1:0] ID_RD_i,
  input  logic            ID_RegWrite_i,
  input  logic            ID_MemRead_i,
  input  logic            Flush_i,
  output logic [1:0]      ForwardA_o,
  output logic [1:0]      ForwardB_o,
  output logic            Stall_o,
  output logic [15:0]     StallCnt_o,
  output logic            Error_o
);

  ex_rec_t    ex_q, ex_d;
  stage_rec_t mem_q, wb_q;
  state_e     state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [1:0] fwd_a, fwd_b_raw, fwd_b;
  logic       stall;
  logic       load_fwd_err;

  fwd_sel u_fwd_a (
    .src_i (ex_q.rs),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .fwd_o (fwd_a)
  );

  fwd_sel u_fwd_b (
    .src_i (ex_q.rt),
    .mem_i (mem_q),
    .wb_i  (wb_q),
    .fwd_o (fwd_b_raw)
  );

  assign fwd_b = (ex_q.usesrt && ex_q.base.valid) ? fwd_b_raw : FWD_REG;

  // Load in EX feeding the instruction in ID cannot be forwarded in time.
  always_comb begin
    stall = 1'b0;
    if (ID_valid_i && ex_q.base.valid && ex_q.base.memread && (ex_q.base.rd != REG_ZERO) &&
        ((ex_q.base.rd == ID_RS_i) || (ID_UsesRT_i && (ex_q.base.rd == ID_RT_i)))) begin
      stall = 1'b1;
    end
    if (Flush_i) begin
      stall = 1'b0;
    end
  end

  // A MEM-stage load selected by forwarding would deliver an address, not data.
  assign load_fwd_err = ex_q.base.valid && mem_q.memread &&
                        ((fwd_a == FWD_MEM) || (fwd_b == FWD_MEM));

  always_comb begin
    ex_d = '0;
    if (!stall && !Flush_i && ID_valid_i) begin
      ex_d.base.valid    = 1'b1;
      ex_d.base.regwrite = ID_RegWrite_i;
      ex_d.base.memread  = ID_MemRead_i;
      ex_d.base.rd       = ID_RD_i;
      ex_d.rs            = ID_RS_i;
      ex_d.rt            = ID_RT_i;
      ex_d.usesrt        = ID_UsesRT_i;
    end
  end

  always_comb begin
    state_d = StRun;
    if (state_q == StRun && stall) begin
      state_d = StStall;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
    err_d = err_q | ((state_q == StStall) && stall) | load_fwd_err;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= StRun;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q.base;
      wb_q    <= mem_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ForwardA_o = fwd_a;
  assign ForwardB_o = fwd_b;
  assign Stall_o    = stall;
  assign StallCnt_o = cnt_q;
  assign Error_o    = err_q;

endmodule

// File: doc/hazard_fwd_ctrl.md
HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n_i, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port ID_valid_i, input, 1, ID-stage instruction valid.
REQ-004 SHALL have port ID_RS_i, input, 5, ID source register 1.
REQ-005 SHALL have port ID_RT_i, input, 5, ID source register 2.
REQ-006 SHALL have port ID_UsesRT_i, input, 1, ID instruction reads RT as an operand.
REQ-007 SHALL have port ID_RD_i, input, 5, ID destination register.
REQ-008 SHALL have port ID_RegWrite_i, input, 1, ID instruction writes the register file.
REQ-009 SHALL have port ID_MemRead_i, input, 1, ID instruction is a load.
REQ-010 SHALL have port Flush_i, input, 1, discard the ID instruction (taken branch).
REQ-011 SHALL have port ForwardA_o, output, 2, select for the EX RS-operand forwarding mux.
REQ-012 SHALL have port ForwardB_o, output, 2, select for the EX RT-operand forwarding mux.
REQ-013 SHALL have port Stall_o, output, 1, hold PC and IF/ID and inject a bubble into EX.
REQ-014 SHALL have port StallCnt_o, output, 16, count of stall cycles.
REQ-015 SHALL have port Error_o, output, 1, sticky protocol-violation flag.

Function
REQ-016 SHALL keep per-stage records EX, MEM and WB, each holding {valid, regwrite, memread, rd}; the EX record also holds rs, rt and usesrt.
REQ-017 SHALL advance every cycle: WB<=MEM, MEM<=EX, EX<=ID fields, or EX<=bubble (valid=0) when Stall_o=1 or Flush_i=1.
REQ-018 SHALL use the forward encoding 00 = register-file data, 01 = WB write data, 10 = MEM ALU result; 11 SHALL never be driven.
REQ-019 SHALL drive ForwardA_o=10 when MEM.valid, MEM.regwrite, MEM.rd!=0 and MEM.rd==EX.rs.
REQ-020 Otherwise SHALL drive ForwardA_o=01 when the same conditions hold against WB; otherwise 00. MEM has priority over WB.
REQ-021 SHALL compute ForwardB_o identically against EX.rt, and force it to 00 when EX.usesrt=0 or EX.valid=0.
REQ-022 SHALL set ForwardA/B_o combinationally from the registered stage records, with zero added latency.
REQ-023 SHALL assert Stall_o combinationally when ID_valid_i, EX.valid, EX.memread and EX.rd!=0 hold, and EX.rd==ID_RS_i or (ID_UsesRT_i and EX.rd==ID_RT_i).
REQ-024 Flush_i=1 SHALL force Stall_o=0 in the same cycle (flush has priority).
REQ-025 SHALL implement a 2-state FSM: RUN->STALL when Stall_o=1, STALL->RUN unconditionally.
REQ-026 SHALL set Error_o when Stall_o=1 in state STALL, or when a MEM-stage load matches an EX source that forwarding would select; Error_o is cleared only by reset.
REQ-027 SHALL increment StallCnt_o on each cycle with Stall_o=1, saturating at 16'hFFFF.
REQ-028 A load-use hazard SHALL cost exactly one stall cycle; the dependent instruction SHALL then receive ForwardX_o=01.

Reset
REQ-029 On rst_n_i=0 SHALL immediately clear all stage valid bits, FSM=RUN, StallCnt_o=0 and Error_o=0; ForwardA/B_o=00 and Stall_o=0 follow.
REQ-030 Reset asserted mid-stall SHALL abandon the stall; the first cycle after release SHALL see an empty pipeline.

Structure
REQ-031 SHALL take the forward codes (FWD_REG, FWD_WB, FWD_MEM), the FSM state encoding and REG_ZERO from the shared pipeline package.
REQ-032 SHALL instantiate one sub-module, fwd_sel, used twice to compute a single 2-bit forward select from a source register and the MEM/WB records.

Verification
REQ-033 add r3 then sub r4,r3,r1 back-to-back -> ForwardA_o=10 when sub is in EX.
REQ-034 add r3, nop, or r5,r1,r3 (UsesRT=1) -> ForwardB_o=01; same case with UsesRT=0 -> ForwardB_o=00.
REQ-035 lw r2 then add r6,r2,r2 -> Stall_o=1 for exactly one cycle, then ForwardA_o=ForwardB_o=01, StallCnt_o=1.
REQ-036 lw r2 then dependent add with Flush_i=1 -> Stall_o=0, EX receives a bubble, StallCnt_o unchanged.
REQ-037 Writes to r0 from both MEM and WB matching the source -> ForwardA_o=00; with MEM and WB both writing r7 -> ForwardA_o=10.
REQ-038 rst_n_i pulsed low during a stall cycle -> outputs zero immediately; the next dependent pair behaves as in a fresh start.
